// File: rtl/move_sequencer_pkg.sv
// Shared types and constants for the falling-piece move sequencer:
// FSM state encoding, event indices (index order is priority order), default geometry.
package move_sequencer_pkg;

   localparam int DEF_X_BITS   = 4;
   localparam int DEF_Y_BITS   = 5;
   localparam int DEF_ROT_BITS = 2;
   localparam int DEF_SPAWN_X  = 4;
   localparam int DEF_SPAWN_Y  = 0;

   localparam int NUM_EV = 6;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TEST  = 3'd1,
      ST_DROP  = 3'd2,
      ST_LOCK  = 3'd3,
      ST_SPAWN = 3'd4,
      ST_HALT  = 3'd5,
      ST_KICK  = 3'd6
   } state_t;

   // Lower index wins arbitration: tick > left > right > rotate > down > drop.
   typedef enum logic [2:0] {
      EV_TICK  = 3'd0,
      EV_LEFT  = 3'd1,
      EV_RIGHT = 3'd2,
      EV_ROT   = 3'd3,
      EV_DOWN  = 3'd4,
      EV_DROP  = 3'd5
   } ev_t;

   function automatic logic [NUM_EV-1:0] prio_pick(input logic [NUM_EV-1:0] req);
      return req & (~req + {{(NUM_EV-1){1'b0}}, 1'b1});
   endfunction

endpackage

// File: rtl/move_sequencer_if.sv
// Candidate-test handshake between the move sequencer (master) and the collision checker (slave).
interface move_sequencer_if #(
   parameter int X_BITS   = 4,
   parameter int Y_BITS   = 5,
   parameter int ROT_BITS = 2
);
   logic                test_req;
   logic [X_BITS-1:0]   test_pos_x;
   logic [Y_BITS-1:0]   test_pos_y;
   logic [ROT_BITS-1:0] test_rot;
   logic                test_ack;
   logic                test_hit;

   modport master (
      output test_req, test_pos_x, test_pos_y, test_rot,
      input  test_ack, test_hit
   );

   modport slave (
      input  test_req, test_pos_x, test_pos_y, test_rot,
      output test_ack, test_hit
   );
endinterface

// File: rtl/move_sequencer_arbiter.sv
// Sticky per-event pending bits with fixed-priority one-hot grant.
// A pulse in the current cycle is visible to the grant immediately so IDLE can launch without delay.
module move_arbiter
   import move_sequencer_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush_i,
   input  logic [NUM_EV-1:0] set_i,
   input  logic [NUM_EV-1:0] clr_i,
   output logic [NUM_EV-1:0] grant_o
);

   logic [NUM_EV-1:0] pend_q;
   logic [NUM_EV-1:0] pend_d;
   logic [NUM_EV-1:0] merged_s;

   // Next pending set: merge new pulses, drop the launched event, or flush everything.
   always_comb begin
      merged_s = pend_q | set_i;
      if (flush_i) begin
         pend_d = '0;
      end else begin
         pend_d = merged_s & ~clr_i;
      end
   end

   // Pending register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q <= '0;
      end else begin
         pend_q <= pend_d;
      end
   end

   assign grant_o = prio_pick(merged_s);

endmodule

// File: rtl/move_sequencer.sv
// Sequences piece moves, hard drop, lock and respawn through the shared collision checker.
// Define MOVE_SEQUENCER_WALL_KICK_EN to retry a blocked rotation at x-1 then x+1.
module move_sequencer
   import move_sequencer_pkg::*;
#(
   parameter int X_BITS   = DEF_X_BITS,
   parameter int Y_BITS   = DEF_Y_BITS,
   parameter int ROT_BITS = DEF_ROT_BITS,
   parameter int SPAWN_X  = DEF_SPAWN_X,
   parameter int SPAWN_Y  = DEF_SPAWN_Y
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                play_en_i,
   input  logic                game_tick_i,
   input  logic                btn_left_en_i,
   input  logic                btn_right_en_i,
   input  logic                btn_rotate_en_i,
   input  logic                btn_down_en_i,
   input  logic                btn_drop_en_i,
   move_sequencer_if.master    test_if,
   output logic [X_BITS-1:0]   cur_pos_x_o,
   output logic [Y_BITS-1:0]   cur_pos_y_o,
   output logic [ROT_BITS-1:0] cur_rot_o,
   output logic                lock_pulse_o,
   output logic                game_over_o
);

   state_t              state_q;
   ev_t                 kind_q;
   logic [X_BITS-1:0]   cur_x_q;
   logic [Y_BITS-1:0]   cur_y_q;
   logic [ROT_BITS-1:0] cur_rot_q;
   logic [X_BITS-1:0]   tst_x_q;
   logic [Y_BITS-1:0]   tst_y_q;
   logic [ROT_BITS-1:0] tst_rot_q;
   logic                req_q;
   logic                lock_q;
   logic                game_over_q;
   logic                drop_mode_q;
`ifdef MOVE_SEQUENCER_WALL_KICK_EN
   logic [1:0]          kick_q;
`endif

   logic [NUM_EV-1:0]   set_s;
   logic [NUM_EV-1:0]   clr_s;
   logic [NUM_EV-1:0]   grant_s;
   logic                flush_s;
   logic [X_BITS-1:0]   cand_x_s;
   logic [Y_BITS-1:0]   cand_y_s;
   logic [ROT_BITS-1:0] cand_rot_s;
   ev_t                 cand_kind_s;

   assign set_s = {btn_drop_en_i, btn_down_en_i, btn_rotate_en_i,
                   btn_right_en_i, btn_left_en_i, game_tick_i};

   // Pending-bit maintenance: clear on launch, ticks ignored during drop, flush on lock or leaving play.
   always_comb begin
      clr_s   = '0;
      flush_s = 1'b0;
      if (state_q != ST_HALT && !play_en_i) begin
         flush_s = 1'b1;
      end else if (state_q == ST_LOCK) begin
         flush_s = 1'b1;
      end else if (state_q == ST_IDLE) begin
         clr_s = grant_s;
      end else if (state_q == ST_DROP) begin
         clr_s[EV_TICK] = 1'b1;
      end else begin
         clr_s = '0;
      end
   end

   move_arbiter u_arbiter (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush_i (flush_s),
      .set_i   (set_s),
      .clr_i   (clr_s),
      .grant_o (grant_s)
   );

   // Candidate position for the granted event.
   always_comb begin
      cand_x_s    = cur_x_q;
      cand_y_s    = cur_y_q;
      cand_rot_s  = cur_rot_q;
      cand_kind_s = EV_TICK;
      if (grant_s[EV_TICK]) begin
         cand_y_s    = cur_y_q + Y_BITS'(1);
         cand_kind_s = EV_TICK;
      end else if (grant_s[EV_LEFT]) begin
         cand_x_s    = cur_x_q - X_BITS'(1);
         cand_kind_s = EV_LEFT;
      end else if (grant_s[EV_RIGHT]) begin
         cand_x_s    = cur_x_q + X_BITS'(1);
         cand_kind_s = EV_RIGHT;
      end else if (grant_s[EV_ROT]) begin
         cand_rot_s  = cur_rot_q + ROT_BITS'(1);
         cand_kind_s = EV_ROT;
      end else if (grant_s[EV_DOWN]) begin
         cand_y_s    = cur_y_q + Y_BITS'(1);
         cand_kind_s = EV_DOWN;
      end else if (grant_s[EV_DROP]) begin
         cand_y_s    = cur_y_q + Y_BITS'(1);
         cand_kind_s = EV_DROP;
      end else begin
         cand_kind_s = EV_TICK;
      end
   end

   // Sequencer FSM; test_pos falls back to cur_* whenever a candidate is discarded.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         kind_q      <= EV_TICK;
         cur_x_q     <= X_BITS'(SPAWN_X);
         cur_y_q     <= Y_BITS'(SPAWN_Y);
         cur_rot_q   <= '0;
         tst_x_q     <= X_BITS'(SPAWN_X);
         tst_y_q     <= Y_BITS'(SPAWN_Y);
         tst_rot_q   <= '0;
         req_q       <= 1'b0;
         lock_q      <= 1'b0;
         game_over_q <= 1'b0;
         drop_mode_q <= 1'b0;
`ifdef MOVE_SEQUENCER_WALL_KICK_EN
         kick_q      <= 2'd0;
`endif
      end else if (state_q != ST_HALT && !play_en_i) begin
         state_q     <= ST_IDLE;
         req_q       <= 1'b0;
         lock_q      <= 1'b0;
         drop_mode_q <= 1'b0;
         tst_x_q     <= cur_x_q;
         tst_y_q     <= cur_y_q;
         tst_rot_q   <= cur_rot_q;
      end else begin
         lock_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (|grant_s) begin
                  req_q     <= 1'b1;
                  tst_x_q   <= cand_x_s;
                  tst_y_q   <= cand_y_s;
                  tst_rot_q <= cand_rot_s;
                  kind_q    <= cand_kind_s;
                  state_q   <= ST_TEST;
                  if (cand_kind_s == EV_DROP) begin
                     drop_mode_q <= 1'b1;
                  end
`ifdef MOVE_SEQUENCER_WALL_KICK_EN
                  kick_q <= 2'd0;
`endif
               end
            end
            ST_TEST: begin
               if (test_if.test_ack && req_q) begin
                  req_q <= 1'b0;
                  if (!test_if.test_hit) begin
                     cur_x_q   <= tst_x_q;
                     cur_y_q   <= tst_y_q;
                     cur_rot_q <= tst_rot_q;
                     state_q   <= drop_mode_q ? ST_DROP : ST_IDLE;
                  end else if (kind_q == EV_ROT) begin
`ifdef MOVE_SEQUENCER_WALL_KICK_EN
                     if (kick_q == 2'd0) begin
                        tst_x_q <= cur_x_q - X_BITS'(1);
                        kick_q  <= 2'd1;
                        state_q <= ST_KICK;
                     end else if (kick_q == 2'd1) begin
                        tst_x_q <= cur_x_q + X_BITS'(1);
                        kick_q  <= 2'd2;
                        state_q <= ST_KICK;
                     end else begin
                        tst_x_q   <= cur_x_q;
                        tst_rot_q <= cur_rot_q;
                        state_q   <= ST_IDLE;
                     end
`else
                     tst_rot_q <= cur_rot_q;
                     state_q   <= ST_IDLE;
`endif
                  end else if (kind_q == EV_LEFT || kind_q == EV_RIGHT) begin
                     tst_x_q <= cur_x_q;
                     state_q <= ST_IDLE;
                  end else begin
                     tst_y_q <= cur_y_q;
                     lock_q  <= 1'b1;
                     state_q <= ST_LOCK;
                  end
               end
            end
            ST_KICK: begin
               req_q   <= 1'b1;
               state_q <= ST_TEST;
            end
            ST_DROP: begin
               req_q     <= 1'b1;
               tst_x_q   <= cur_x_q;
               tst_y_q   <= cur_y_q + Y_BITS'(1);
               tst_rot_q <= cur_rot_q;
               kind_q    <= EV_DROP;
               state_q   <= ST_TEST;
            end
            ST_LOCK: begin
               drop_mode_q <= 1'b0;
               req_q       <= 1'b1;
               tst_x_q     <= X_BITS'(SPAWN_X);
               tst_y_q     <= Y_BITS'(SPAWN_Y);
               tst_rot_q   <= '0;
               state_q     <= ST_SPAWN;
            end
            ST_SPAWN: begin
               if (test_if.test_ack && req_q) begin
                  req_q <= 1'b0;
                  if (!test_if.test_hit) begin
                     cur_x_q   <= tst_x_q;
                     cur_y_q   <= tst_y_q;
                     cur_rot_q <= tst_rot_q;
                     state_q   <= ST_IDLE;
                  end else begin
                     game_over_q <= 1'b1;
                     tst_x_q     <= cur_x_q;
                     tst_y_q     <= cur_y_q;
                     tst_rot_q   <= cur_rot_q;
                     state_q     <= ST_HALT;
                  end
               end
            end
            ST_HALT: begin
               state_q <= ST_HALT;
            end
            default: begin
               req_q   <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign test_if.test_req   = req_q;
   assign test_if.test_pos_x = tst_x_q;
   assign test_if.test_pos_y = tst_y_q;
   assign test_if.test_rot   = tst_rot_q;
   assign cur_pos_x_o        = cur_x_q;
   assign cur_pos_y_o        = cur_y_q;
   assign cur_rot_o          = cur_rot_q;
   assign lock_pulse_o       = lock_q;
   assign game_over_o        = game_over_q;

endmodule

// File: tb/tb_move_sequencer.sv
// Scoreboard bench for move_sequencer: expected test positions are queued by the stimulus
// and popped by a monitor on each rising test_req; a behavioural checker answers the tests.
module tb_move_sequencer;

   logic       clk;
   logic       rst_n;
   logic       play_en;
   logic       game_tick, b_left, b_right, b_rot, b_down, b_drop;
   logic [3:0] cur_x;
   logic [4:0] cur_y;
   logic [1:0] cur_rot;
   logic       lock_pulse;
   logic       game_over;

   move_sequencer_if #(.X_BITS(4), .Y_BITS(5), .ROT_BITS(2)) ifc ();

   move_sequencer #(.X_BITS(4), .Y_BITS(5), .ROT_BITS(2), .SPAWN_X(4), .SPAWN_Y(0)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .play_en_i       (play_en),
      .game_tick_i     (game_tick),
      .btn_left_en_i   (b_left),
      .btn_right_en_i  (b_right),
      .btn_rotate_en_i (b_rot),
      .btn_down_en_i   (b_down),
      .btn_drop_en_i   (b_drop),
      .test_if         (ifc),
      .cur_pos_x_o     (cur_x),
      .cur_pos_y_o     (cur_y),
      .cur_rot_o       (cur_rot),
      .lock_pulse_o    (lock_pulse),
      .game_over_o     (game_over)
   );

   int          checks    = 0;
   int          errors    = 0;
   logic [10:0] exp_q[$];
   int          hit_y     = 32;
   logic        spawn_hit = 1'b0;
   logic        kick_mode = 1'b0;
   logic        resp_en   = 1'b1;
   logic        stray_ack = 1'b0;
   int          lock_cnt  = 0;
   int          lock_y    = -1;

   localparam logic [5:0] E_TICK  = 6'b000001;
   localparam logic [5:0] E_LEFT  = 6'b000010;
   localparam logic [5:0] E_RIGHT = 6'b000100;
   localparam logic [5:0] E_ROT   = 6'b001000;
   localparam logic [5:0] E_DOWN  = 6'b010000;
   localparam logic [5:0] E_DROP  = 6'b100000;

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic push(input int x, input int y, input int r);
      exp_q.push_back({4'(x), 5'(y), 2'(r)});
   endtask

   function automatic logic hit_fn(input logic [3:0] x, input logic [4:0] y, input logic [1:0] r);
      return (int'(y) >= hit_y)
          || (spawn_hit && x == 4'd4 && y == 5'd0 && r == 2'd0)
          || (kick_mode && r == 2'd1 && (x == 4'd0 || x == 4'd15));
   endfunction

   // Monitor: compare each new test request with the head of the expectation queue.
   initial begin : monitor
      logic        prev_req;
      logic [10:0] got;
      logic [10:0] want;
      prev_req = 1'b0;
      forever begin
         @(negedge clk);
         if (ifc.test_req && !prev_req) begin
            got = {ifc.test_pos_x, ifc.test_pos_y, ifc.test_rot};
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_test: got (%0d,%0d,%0d) with none queued",
                        got[10:7], got[6:2], got[1:0]);
            end else begin
               want = exp_q.pop_front();
               if (got != want) begin
                  errors++;
                  $display("FAIL test_pos: got (%0d,%0d,%0d) expected (%0d,%0d,%0d)",
                           got[10:7], got[6:2], got[1:0], want[10:7], want[6:2], want[1:0]);
               end
            end
         end
         prev_req = ifc.test_req;
         if (lock_pulse) begin
            lock_cnt++;
            lock_y = int'(cur_y);
         end
      end
   end

   // Collision checker model: acknowledges one cycle after seeing a request.
   initial begin : responder
      logic seen;
      logic acked;
      seen  = 1'b0;
      acked = 1'b0;
      ifc.test_ack = 1'b0;
      ifc.test_hit = 1'b0;
      forever begin
         @(negedge clk);
         ifc.test_ack = 1'b0;
         if (acked) begin
            chk("req_low_after_ack", int'(ifc.test_req), 0);
            acked = 1'b0;
         end
         if (stray_ack) begin
            ifc.test_ack = 1'b1;
            ifc.test_hit = 1'b0;
            seen = 1'b0;
         end else if (resp_en && ifc.test_req) begin
            if (seen) begin
               ifc.test_ack = 1'b1;
               ifc.test_hit = hit_fn(ifc.test_pos_x, ifc.test_pos_y, ifc.test_rot);
               seen  = 1'b0;
               acked = 1'b1;
            end else begin
               seen = 1'b1;
            end
         end else begin
            seen = 1'b0;
         end
      end
   end

   task automatic pulse(input logic [5:0] ev);
      @(negedge clk);
      {b_drop, b_down, b_rot, b_right, b_left, game_tick} = ev;
      @(negedge clk);
      {b_drop, b_down, b_rot, b_right, b_left, game_tick} = 6'b0;
   endtask

   task automatic wait_quiet(input string tag);
      int quiet = 0;
      int n     = 0;
      while (quiet < 4 && n < 400) begin
         @(negedge clk);
         n++;
         if (!ifc.test_req && exp_q.size() == 0) quiet++;
         else quiet = 0;
      end
      if (quiet < 4) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: got %0d pending expected 0", tag, exp_q.size());
      end
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_cur_x"}, int'(cur_x), 4);
      chk({tag, "_cur_y"}, int'(cur_y), 0);
      chk({tag, "_cur_rot"}, int'(cur_rot), 0);
      chk({tag, "_tpos"}, int'({ifc.test_pos_x, ifc.test_pos_y, ifc.test_rot}), int'({4'd4, 5'd0, 2'd0}));
      chk({tag, "_req"}, int'(ifc.test_req), 0);
      chk({tag, "_lock"}, int'(lock_pulse), 0);
      chk({tag, "_game_over"}, int'(game_over), 0);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_reset(tag);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: got no finish expected finish");
      $fatal(1, "watchdog");
   end

   initial begin : stim
      logic any_req;
      rst_n   = 1'b0;
      play_en = 1'b1;
      {b_drop, b_down, b_rot, b_right, b_left, game_tick} = 6'b0;
      do_reset("reset");

      // Gravity tick, no collision; request must be up the cycle after the pulse.
      push(4, 1, 0);
      pulse(E_TICK);
      chk("tick_req_latency", int'(ifc.test_req), 1);
      wait_quiet("tick");
      chk("tick_cur_y", int'(cur_y), 1);

      // Simultaneous left/right/rotate served in priority order.
      push(3, 1, 0);
      push(4, 1, 0);
      push(4, 1, 1);
      pulse(E_LEFT | E_RIGHT | E_ROT);
      wait_quiet("lrr");
      chk("lrr_cur", int'({cur_x, cur_y, cur_rot}), int'({4'd4, 5'd1, 2'd1}));

      // Hard drop from y=1, floor at y=6, then respawn.
      hit_y = 6;
      for (int y = 2; y <= 6; y++) push(4, y, 1);
      push(4, 0, 0);
      pulse(E_DROP);
      wait_quiet("drop");
      chk("drop_lock_cnt", lock_cnt, 1);
      chk("drop_lock_y", lock_y, 5);
      chk("spawn_cur", int'({cur_x, cur_y, cur_rot}), int'({4'd4, 5'd0, 2'd0}));
      chk("drop_game_over", int'(game_over), 0);
      hit_y = 32;

      // Walk down to y=19, then a tick hits and the respawn collides.
      for (int y = 1; y <= 19; y++) begin
         push(4, y, 0);
         pulse(E_DOWN);
         wait_quiet("down");
      end
      chk("down_cur_y", int'(cur_y), 19);
      hit_y     = 20;
      spawn_hit = 1'b1;
      push(4, 20, 0);
      push(4, 0, 0);
      pulse(E_TICK);
      wait_quiet("over");
      chk("over_game_over", int'(game_over), 1);
      chk("over_lock_cnt", lock_cnt, 2);
      chk("over_cur_y", int'(cur_y), 19);
      any_req = 1'b0;
      pulse(E_LEFT | E_TICK);
      repeat (8) begin
         @(negedge clk);
         any_req = any_req | ifc.test_req;
      end
      chk("halt_no_req", int'(any_req), 0);

      // Rotation blocked at the left wall.
      do_reset("reset2");
      hit_y     = 32;
      spawn_hit = 1'b0;
      for (int x = 3; x >= 0; x--) begin
         push(x, 0, 0);
         pulse(E_LEFT);
         wait_quiet("left");
      end
      chk("wall_cur_x", int'(cur_x), 0);
      kick_mode = 1'b1;
`ifdef MOVE_SEQUENCER_WALL_KICK_EN
      push(0, 0, 1);
      push(15, 0, 1);
      push(1, 0, 1);
      pulse(E_ROT);
      wait_quiet("kick");
      chk("kick_cur", int'({cur_x, cur_y, cur_rot}), int'({4'd1, 5'd0, 2'd1}));
`else
      push(0, 0, 1);
      pulse(E_ROT);
      wait_quiet("nokick");
      chk("nokick_cur", int'({cur_x, cur_y, cur_rot}), int'({4'd0, 5'd0, 2'd0}));
`endif
      kick_mode = 1'b0;

      // Reset while a test is outstanding; a later stray ack must do nothing.
      resp_en = 1'b0;
`ifdef MOVE_SEQUENCER_WALL_KICK_EN
      push(1, 1, 1);
`else
      push(0, 1, 0);
`endif
      pulse(E_TICK);
      chk("mid_req_high", int'(ifc.test_req), 1);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_reset("mid_rst");
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1 stray_ack = 1'b1;
      @(posedge clk);
      #1 stray_ack = 1'b0;
      any_req = 1'b0;
      repeat (5) begin
         @(negedge clk);
         any_req = any_req | ifc.test_req;
      end
      chk("stray_no_req", int'(any_req), 0);
      chk("stray_cur", int'({cur_x, cur_y, cur_rot}), int'({4'd4, 5'd0, 2'd0}));
      chk("stray_queue_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/move_sequencer.md
# move_sequencer

Sequences every candidate move of the falling piece through the shared collision checker, one request at a time. It latches the game-clock tick and the button enables, arbitrates them by fixed priority, presents one test position/rotation, and commits or discards it on the checker's answer. It also handles hard drop, lock and respawn. It sits between the input debouncers/game clock and the board/collision logic in the play datapath.

## Interface
Parameters:
- X_BITS, 4, width of x position
- Y_BITS, 5, width of y position
- ROT_BITS, 2, width of rotation index
- SPAWN_X, 4, x of a newly spawned piece
- SPAWN_Y, 0, y of a newly spawned piece

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, asynchronous assert, active-low
- play_en  in  1  game in play mode; when low, pending events are cleared and FSM holds IDLE
- game_tick  in  1  one-cycle gravity pulse
- btn_left_en / btn_right_en / btn_rotate_en / btn_down_en / btn_drop_en  in  1 each  one-cycle button pulses
- test_req  out  1  candidate valid; held until acknowledged
- test_pos_x  out  X_BITS  candidate x
- test_pos_y  out  Y_BITS  candidate y
- test_rot  out  ROT_BITS  candidate rotation
- test_ack  in  1  checker answer valid (one cycle, ≥1 cycle after test_req rises)
- test_hit  in  1  candidate collides (sampled with test_ack)
- cur_pos_x / cur_pos_y / cur_rot  out  X_BITS / Y_BITS / ROT_BITS  committed piece state
- lock_pulse  out  1  one cycle: piece merged into board at cur_*
- game_over  out  1  sticky: spawn position collided

## Operation
- Pending register: one sticky bit per event (tick, left, right, rotate, down, drop). A pulse sets its bit in any state; repeated pulses while pending merge into one.
- Priority when leaving IDLE: tick > left > right > rotate > down > drop. The bit is cleared when its test is launched.
- Candidate, all arithmetic modulo field width:
  - tick/down: y+1
  - left: x−1
  - right: x+1
  - rotate: rot+1
- States:
  - IDLE: if a bit is pending, go to TEST.
  - TEST: assert test_req with the candidate. On test_ack:
    - !hit: commit candidate to cur_*, go to IDLE (or DROP if drop mode).
    - hit on tick, down or drop-step: go to LOCK.
    - hit on left/right/rotate: discard, go to IDLE.
  - DROP: launch a y+1 test each entry. Ignores all other pending bits except tick, which is cleared.
  - LOCK: lock_pulse=1 for one cycle; clear all pending bits; go to SPAWN.
  - SPAWN: test (SPAWN_X, SPAWN_Y, rot 0).
    - !hit: commit, go to IDLE.
    - hit: set game_over, go to HALT.
  - HALT: terminal until reset.
- The drop event launches a y+1 test and sets drop mode. Drop mode clears on LOCK.
- play_en low in any state other than HALT: drop test_req the next cycle; discard a late test_ack; go to IDLE; clear pending and drop mode.

## Timing
- Reset values:
  - cur_pos_x=SPAWN_X, cur_pos_y=SPAWN_Y, cur_rot=0
  - test_pos_* equal to cur_*
  - test_req=0, lock_pulse=0, game_over=0
  - FSM IDLE, pending=0
- Event pulse at cycle n with FSM idle: test_req high at n+1.
- cur_* update the cycle after test_ack. The next test_req can rise one cycle after that.
- test_pos_* are stable while test_req is high.
- test_ack while test_req is low is ignored.
- Simultaneous pulses are all latched; they are served in priority order, one test each.

## Configuration
- MOVE_SEQUENCER_WALL_KICK_EN defined:
  - A rotate rejected by hit retries the same rotation at x−1, then at x+1.
  - The first non-hit retry commits. The rotate is discarded only after all three tries hit.
  - Two extra test transactions maximum.
- Not defined: a rejected rotate is discarded immediately.

## Structure
- Shared package/header holds:
  - state encoding constants
  - event index constants and the priority order
  - default widths matching the board geometry
- Sub-module move_arbiter: pending sticky bits plus fixed-priority pick. It outputs a one-hot grant and accepts a clear-on-launch input.

## Test plan
- Reset, then game_tick, checker acks !hit after 2 cycles: test (4,1,0), cur_pos_y=1; test_req low the cycle after ack.
- Same-cycle left+right+rotate at (4,1,0), all !hit: tests in order (3,1,0), (4,1,0), (4,1,1); final cur = (4,1,1).
- btn_drop_en at y=1, checker hits at y=6: commits y=2..5; lock_pulse once with cur_y=5; then spawn test (4,0,0).
- game_tick hit at cur_y=19: lock_pulse; spawn hit → game_over=1; later pulses produce no test_req.
- Wall kick enabled, rotate at x=0: hit at (0,y,1) and (15,y,1), !hit at (1,y,1) → cur_x=1, rot=1. Disabled: single test, cur unchanged.
- rst_n low mid-TEST with test_req high: all outputs at reset values immediately; a later stray test_ack is ignored.
